// File: rtl/sort_pkg.sv
// Shared types and constants for the compare-exchange sort sequencer.
package sort_pkg;

  localparam logic signed [15:0] DATA_MIN = 16'sh8000;
  localparam int DEPTH_DEF = 16;
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sort_out_fifo.sv
// Small synchronous FIFO holding {last, data} for the sorted output stream.
module sort_out_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [W-1:0]                   din,
  input  logic                           pop,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCW = $clog2(DEPTH + 1);
  localparam logic [FCW-1:0] FULL   = FCW'(DEPTH);
  localparam logic [AW-1:0]  LAST_A = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  // storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_A) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_A) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + FCW'(1);
        2'b01:   count <= count - FCW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequencer for a DEPTH-cell compare-exchange sort chain: loads a frame, drains it largest first.
// Optional SORT_SEQ_ERR_EN adds err_ovf (frame overflow pulse) and frm_cnt (completed frames).
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CHAIN_LAT = 1,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic                 chain_vld,
  output logic                 chain_dir,
  output logic signed [DW-1:0] chain_din,
  input  logic signed [DW-1:0] chain_dout,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last
`ifdef SORT_SEQ_ERR_EN
  ,
  output logic                 err_ovf,
  output logic [15:0]          frm_cnt
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam int FD = CHAIN_LAT + 2;
  localparam int FW = $clog2(FD + 1);
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_V  = CW'(DEPTH - 1);
  localparam logic [FW:0]   FD_V    = (FW + 1)'(FD);
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       n_cnt;
  logic [CW-1:0]       pls_cnt;
  logic [CW-1:0]       cap_cnt;
  logic [CHAIN_LAT-1:0] vld_p;
  logic [FW-1:0]       inflight;
  logic [FW-1:0]       fifo_cnt;
  logic [DW:0]         fifo_din;
  logic [DW:0]         fifo_dout;
  logic                accept;
  logic                pulse;
  logic                cap;
  logic                push;
  logic                pop;
  logic                credit_ok;
  logic                frame_end;
  logic                drain_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CHAIN_LAT; i++) inflight = inflight + FW'(vld_p[i]);
  end

  // in-flight drain pulses reserve a FIFO slot, including ones that will be discarded
  assign credit_ok  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < FD_V;
  assign frame_end  = s_last || (n_cnt == LAST_V);
  assign drain_done = (pls_cnt == DEPTH_V) && (inflight == '0) && (fifo_cnt == '0);

  always_comb begin
    state_nxt = state;
    s_rdy     = 1'b0;
    accept    = 1'b0;
    pulse     = 1'b0;
    chain_vld = 1'b0;
    chain_dir = 1'b0;
    chain_din = MIN_V;
    case (state)
      IDLE: begin
        if (s_vld) state_nxt = LOAD;
      end
      LOAD: begin
        s_rdy  = 1'b1;
        accept = s_vld;
        if (accept) begin
          chain_vld = 1'b1;
          chain_din = s_data;
          if (frame_end) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        chain_dir = 1'b1;
        pulse     = (pls_cnt != DEPTH_V) && credit_ok;
        chain_vld = pulse;
        if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stage boundary: drain pulse -> chain_dout capture after CHAIN_LAT cycles
  assign cap      = vld_p[CHAIN_LAT-1];
  assign push     = cap && (cap_cnt < n_cnt);
  assign fifo_din = {(cap_cnt + CW'(1)) == n_cnt, chain_dout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_cnt   <= '0;
      pls_cnt <= '0;
      cap_cnt <= '0;
      vld_p   <= '0;
    end else begin
      state <= state_nxt;
      vld_p <= (vld_p << 1) | CHAIN_LAT'(pulse);
      if (state == IDLE) begin
        n_cnt   <= '0;
        pls_cnt <= '0;
        cap_cnt <= '0;
      end else begin
        if (accept) n_cnt   <= n_cnt + CW'(1);
        if (pulse)  pls_cnt <= pls_cnt + CW'(1);
        if (cap)    cap_cnt <= cap_cnt + CW'(1);
      end
    end
  end

  sort_out_fifo #(
    .W     (DW + 1),
    .DEPTH (FD)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  assign m_vld  = (fifo_cnt != '0);
  assign pop    = m_vld && m_rdy;
  assign m_data = m_vld ? $signed(fifo_dout[DW-1:0]) : '0;
  assign m_last = m_vld && fifo_dout[DW];

`ifdef SORT_SEQ_ERR_EN
  logic ovf_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
      frm_cnt    <= '0;
    end else begin
      err_ovf <= accept && !s_last && (n_cnt == LAST_V);
      if (accept && !s_last && (n_cnt == LAST_V)) ovf_sticky <= 1'b1;
      if ((state == DRAIN) && drain_done) frm_cnt <= frm_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl with a behavioural sort-chain model and output scoreboard.
module tb_sort_seq_ctrl;
  import sort_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int FD    = LAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_vld = 1'b0;
  logic s_last = 1'b0;
  logic m_rdy = 1'b0;
  logic signed [15:0] s_data = '0;
  logic signed [15:0] chain_dout = '0;
  logic s_rdy, chain_vld, chain_dir, m_vld, m_last;
  logic signed [15:0] chain_din, m_data;
`ifdef SORT_SEQ_ERR_EN
  logic err_ovf;
  logic [15:0] frm_cnt;
`endif

  always #5 clk = ~clk;

  sort_seq_ctrl #(.DEPTH(DEPTH), .CHAIN_LAT(LAT), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data), .s_last(s_last),
    .chain_vld(chain_vld), .chain_dir(chain_dir), .chain_din(chain_din), .chain_dout(chain_dout),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_last(m_last)
`ifdef SORT_SEQ_ERR_EN
    , .err_ovf(err_ovf), .frm_cnt(frm_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  typedef struct { bit last; logic signed [15:0] d; } exp_t;
  exp_t expq[$];

  typedef struct { int n; bit lst; logic signed [15:0] d [4]; logic signed [15:0] e [4]; } vec_t;
  vec_t tab [6];

  task automatic set_vec(input int i, input int n, input bit lst,
                         input int d0, input int d1, input int d2, input int d3,
                         input int e0, input int e1, input int e2, input int e3);
    tab[i].n = n; tab[i].lst = lst;
    tab[i].d[0] = 16'(d0); tab[i].d[1] = 16'(d1); tab[i].d[2] = 16'(d2); tab[i].d[3] = 16'(d3);
    tab[i].e[0] = 16'(e0); tab[i].e[1] = 16'(e1); tab[i].e[2] = 16'(e2); tab[i].e[3] = 16'(e3);
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_rdy = 1'b0;
      1:       m_rdy = 1'b1;
      default: m_rdy = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Behavioural chain: load keeps the DEPTH largest values, drain yields the max and refills with chain_din.
  logic smp_vld = 1'b0, smp_dir = 1'b0;
  logic signed [15:0] smp_din = '0;
  logic signed [15:0] cells [DEPTH];
  logic signed [15:0] dly [LAT];

  initial forever begin : chain_model
    int idx;
    logic signed [15:0] r;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cells[i] = DATA_MIN;
      for (int i = 0; i < LAT; i++) dly[i] = '0;
      chain_dout <= '0;
    end else begin
      r = DATA_MIN;
      idx = 0;
      if (smp_vld && !smp_dir) begin
        for (int i = 1; i < DEPTH; i++) if (cells[i] < cells[idx]) idx = i;
        if (smp_din > cells[idx]) cells[idx] = smp_din;
      end else if (smp_vld && smp_dir) begin
        for (int i = 1; i < DEPTH; i++) if (cells[i] > cells[idx]) idx = i;
        r = cells[idx];
        cells[idx] = smp_din;
      end
      for (int i = LAT - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = r;
      chain_dout <= dly[LAT-1];
    end
  end

  int acc = 0, pcnt = 0, ocnt = 0, fn = 0, t_end = 0, ovf_seen = 0;
  bit prev_dir = 1'b0, lat_arm = 1'b0;

  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    smp_vld = chain_vld;
    smp_dir = chain_dir;
    smp_din = chain_din;
    if (!rst_n) begin
      acc = 0; pcnt = 0; ocnt = 0; fn = 0;
      prev_dir = 1'b0; lat_arm = 1'b0;
    end else begin
`ifdef SORT_SEQ_ERR_EN
      if (err_ovf) ovf_seen++;
`endif
      if (s_vld && s_rdy) begin
        acc++;
        if (s_last || acc == DEPTH) begin
          lat_arm = 1'b1;
          t_end = cyc;
        end
      end
      if (m_vld && lat_arm) begin
        check("latency", cyc - t_end, LAT + 2);
        lat_arm = 1'b0;
      end
      if (chain_vld && chain_dir) begin
        if (pcnt == 0) begin
          fn = acc;
          acc = 0;
        end
        if (pcnt < fn) check("credit", 32'((pcnt + 1 - ocnt) <= FD), 1);
        pcnt++;
      end
      if (m_vld && m_rdy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got %0d required no output", m_data);
        end else begin
          e = expq.pop_front();
          check("m_data", m_data, e.d);
          check("m_last", m_last, e.last);
          ocnt++;
        end
      end
      if (prev_dir && !chain_dir) begin
        check("drain_pulses", pcnt, DEPTH);
        pcnt = 0;
        ocnt = 0;
      end
      prev_dir = chain_dir;
    end
  end

  logic signed [15:0] fbuf [DEPTH];

  task automatic send(input int n, input bit use_last);
    bit hs;
    int w;
    for (int i = 0; i < n; i++) begin
      s_vld = 1'b1;
      s_data = fbuf[i];
      s_last = use_last && (i == n - 1);
      w = 0;
      hs = 1'b0;
      while (!hs && w < 500) begin
        @(negedge clk);
        hs = s_rdy;
        @(posedge clk);
        #1;
        w++;
      end
      if (!hs) begin
        fail_now("send_timeout");
        s_vld = 1'b0; s_last = 1'b0;
        return;
      end
    end
    s_vld = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic push_sorted(input int n);
    logic signed [15:0] t [DEPTH];
    logic signed [15:0] tmp;
    exp_t e;
    for (int i = 0; i < n; i++) t[i] = fbuf[i];
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (t[j] > t[i]) begin
          tmp = t[i]; t[i] = t[j]; t[j] = tmp;
        end
    for (int i = 0; i < n; i++) begin
      e.d = t[i];
      e.last = (i == n - 1);
      expq.push_back(e);
    end
  endtask

  task automatic run_tab(input int k);
    exp_t e;
    for (int i = 0; i < tab[k].n; i++) begin
      fbuf[i] = tab[k].d[i];
      e.d = tab[k].e[i];
      e.last = (i == tab[k].n - 1);
      expq.push_back(e);
    end
    send(tab[k].n, tab[k].lst);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((expq.size() != 0 || chain_dir) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  int ovf_after = 0;
  int frames_after = 0;

  initial begin
    set_vec(0, 4, 1, 5, -3, 100, 0,            100, 5, 0, -3);
    set_vec(1, 1, 1, -32768, 0, 0, 0,          -32768, 0, 0, 0);
    set_vec(2, 2, 1, 1, 2, 0, 0,               2, 1, 0, 0);
    set_vec(3, 3, 1, 7, 7, -7, 0,              7, 7, -7, 0);
    set_vec(4, 4, 1, -1, 32767, -32768, 0,     32767, 0, -1, -32768);
    set_vec(5, 3, 1, 3, -3, 3, 0,              3, 3, -3, 0);

    rdy_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_rdy", s_rdy, 0);
    check("rst_chain_vld", chain_vld, 0);
    check("rst_chain_dir", chain_dir, 0);
    check("rst_chain_din", chain_din, DATA_MIN);
    check("rst_m_vld", m_vld, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
`ifdef SORT_SEQ_ERR_EN
    check("rst_err_ovf", err_ovf, 0);
    check("rst_frm_cnt", frm_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back table frames, then two more under random m_rdy
    for (int k = 0; k < 3; k++) run_tab(k);
    wait_idle();
    rdy_mode = 2;
    run_tab(4);
    run_tab(5);
    wait_idle();

    // full frame with no s_last: drain starts after beat DEPTH
    rdy_mode = 1;
    for (int i = 0; i < DEPTH; i++) fbuf[i] = 16'((i * 37) % 11 * 300 - 1500);
    push_sorted(DEPTH);
    send(DEPTH, 1'b0);
    wait_idle();
`ifdef SORT_SEQ_ERR_EN
    check("ovf_pulses", ovf_seen, 1);
    check("frm_cnt_pre_rst", frm_cnt, 6);
`endif

    // stall the output, then reset in the middle of the drain
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) fbuf[i] = 16'(i * 100 - 400);
    send(10, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("stall_m_vld", m_vld, 1);
    check("stall_chain_dir", chain_dir, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_m_vld", m_vld, 0);
    check("midrst_chain_dir", chain_dir, 0);
    expq.delete();
    ovf_seen = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    run_tab(3);
    frames_after++;
    wait_idle();

    // random frames against the reference sort, m_rdy ~30% high
    rdy_mode = 2;
    for (int f = 0; f < 100; f++) begin
      int n;
      bit lst;
      n = $urandom_range(1, DEPTH);
      lst = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       fbuf[i] = 16'(int'($urandom_range(0, 8)) - 4);
          1:       fbuf[i] = ($urandom_range(0, 7) == 0) ? DATA_MIN : 16'sh7FFF;
          default: fbuf[i] = 16'($urandom_range(0, 65535));
        endcase
      end
      push_sorted(n);
      send(n, lst);
      frames_after++;
      if (n == DEPTH && !lst) ovf_after++;
    end
    wait_idle();
    check("queue_drained", expq.size(), 0);
`ifdef SORT_SEQ_ERR_EN
    check("frm_cnt_final", frm_cnt, frames_after);
    check("ovf_pulses_rand", ovf_seen, ovf_after);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
